etapa_ex_vectorial: RTL

- Execute stage directly downstream of the decode/execute pipeline register.
- Consumes the registered control word, the scalar operands and the 32-element vector operand.
- Scalar ops complete in 1 cycle. Vector ops run multi-cycle, LANES elements per cycle.
- Presents results to the memory stage under a valid/ready handshake and back-pressures the decode side while busy.

---
 rtl/etapa_ex_vectorial_if.sv | 46 ++++
 rtl/etapa_ex_vectorial.sv | 139 +++++++++++++
 2 files changed

// File: rtl/etapa_ex_vectorial_if.sv
// Handshake and data bus between the decode/execute register, the vector
// execute stage and the memory stage. The slave modport is the stage's view.
interface etapa_ex_vectorial_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_ELEM = 32
);
  logic                       InValid;
  logic                       InReady;
  logic [3:0]                 CodigoALUIN;
  logic [1:0]                 MuxResultIN;
  logic                       MuxDatoIN;
  logic                       WriteMemIN;
  logic                       WriteRegIN;
  logic [4:0]                 DirWriteIN;
  logic [4:0]                 OpCodeIN;
  logic [DATA_W-1:0]          ValAIN;
  logic [DATA_W-1:0]          ValBIN;
  logic [DATA_W-1:0]          InmCorrimIN;
  logic [NUM_ELEM*DATA_W-1:0] VecIN;
  logic                       Flush;
  logic                       OutValid;
  logic                       OutReady;
  logic [DATA_W-1:0]          ResultOUT;
  logic [NUM_ELEM*DATA_W-1:0] VecResultOUT;
  logic                       ZeroOUT;
  logic [DATA_W-1:0]          ValBOUT;
  logic [4:0]                 DirWriteOUT;
  logic [4:0]                 OpCodeOUT;
  logic                       WriteMemOUT;
  logic                       WriteRegOUT;
  logic                       BusyOUT;

  modport slave (
    input  InValid, CodigoALUIN, MuxResultIN, MuxDatoIN, WriteMemIN, WriteRegIN,
           DirWriteIN, OpCodeIN, ValAIN, ValBIN, InmCorrimIN, VecIN, Flush, OutReady,
    output InReady, OutValid, ResultOUT, VecResultOUT, ZeroOUT, ValBOUT,
           DirWriteOUT, OpCodeOUT, WriteMemOUT, WriteRegOUT, BusyOUT
  );

  modport master (
    output InValid, CodigoALUIN, MuxResultIN, MuxDatoIN, WriteMemIN, WriteRegIN,
           DirWriteIN, OpCodeIN, ValAIN, ValBIN, InmCorrimIN, VecIN, Flush, OutReady,
    input  InReady, OutValid, ResultOUT, VecResultOUT, ZeroOUT, ValBOUT,
           DirWriteOUT, OpCodeOUT, WriteMemOUT, WriteRegOUT, BusyOUT
  );
endinterface

// File: rtl/etapa_ex_vectorial.sv
// Execute stage: single-cycle scalar ALU ops, multi-cycle vector ops
// processed LANES elements per cycle, valid/ready towards the memory stage.
//
// state | meaning
// IDLE  | no op held, ready to accept
// BUSY  | vector op in progress, one lane group per cycle
// DONE  | results presented; accepts back-to-back when the memory stage takes them
module etapa_ex_vectorial #(
  parameter int DATA_W   = 32,
  parameter int NUM_ELEM = 32,
  parameter int LANES    = 4
) (
  input logic                  clk,
  input logic                  rst,
  etapa_ex_vectorial_if.slave  bus
);
  localparam int GROUPS = NUM_ELEM / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                     r_state, w_next;
  logic [CNT_W-1:0]           r_cnt;
  logic [3:0]                 r_alu;
  logic                       r_wmem, r_wreg, r_zero;
  logic [4:0]                 r_dir, r_op;
  logic [DATA_W-1:0]          r_opb, r_valb, r_result;
  logic [NUM_ELEM*DATA_W-1:0] r_vec, r_vecres;

  logic                       w_accept, w_is_vec, w_in_ready, w_out_valid;
  logic [DATA_W-1:0]          w_opb, w_scalar_res;

  function automatic logic [DATA_W-1:0] f_alu(input logic [3:0] code,
                                              input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] y;
    case (code)
      4'd0:    y = x + b;
      4'd1:    y = x - b;
      4'd2:    y = x & b;
      4'd3:    y = x | b;
      4'd4:    y = x ^ b;
      4'd5:    y = x << b[4:0];
      4'd6:    y = x >> b[4:0];
      4'd7:    y = $signed(x) >>> b[4:0];
      default: y = x;
    endcase
    return y;
  endfunction

  assign w_opb        = bus.MuxDatoIN ? bus.InmCorrimIN : bus.ValBIN;
  assign w_is_vec     = (bus.MuxResultIN == 2'b01);
  assign w_scalar_res = (bus.MuxResultIN == 2'b10) ? bus.ValAIN
                                                   : f_alu(bus.CodigoALUIN, bus.ValAIN, w_opb);
  assign w_in_ready   = (r_state == IDLE) | ((r_state == DONE) & bus.OutReady);
  assign w_accept     = bus.InValid & w_in_ready & ~bus.Flush;
  assign w_out_valid  = (r_state == DONE);

  assign bus.InReady      = w_in_ready;
  assign bus.OutValid     = w_out_valid;
  assign bus.BusyOUT      = (r_state == BUSY);
  assign bus.ResultOUT    = r_result;
  assign bus.ZeroOUT      = r_zero;
  assign bus.VecResultOUT = r_vecres;
  assign bus.ValBOUT      = r_valb;
  assign bus.DirWriteOUT  = r_dir;
  assign bus.OpCodeOUT    = r_op;
  assign bus.WriteMemOUT  = r_wmem & w_out_valid;
  assign bus.WriteRegOUT  = r_wreg & w_out_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state: flush wins over everything, DONE may chain straight into a new op
  always_comb begin
    w_next = r_state;
    if (bus.Flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = w_is_vec ? BUSY : DONE;
        BUSY:    if (r_cnt == LAST) w_next = DONE;
        DONE: begin
          if (w_accept)          w_next = w_is_vec ? BUSY : DONE;
          else if (bus.OutReady) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Operand capture, scalar result at accept, one lane group per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_alu    <= '0;
      r_wmem   <= 1'b0;
      r_wreg   <= 1'b0;
      r_zero   <= 1'b0;
      r_dir    <= '0;
      r_op     <= '0;
      r_opb    <= '0;
      r_valb   <= '0;
      r_result <= '0;
      r_vec    <= '0;
      r_vecres <= '0;
    end else if (bus.Flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_alu  <= bus.CodigoALUIN;
      r_wmem <= bus.WriteMemIN;
      r_wreg <= bus.WriteRegIN;
      r_dir  <= bus.DirWriteIN;
      r_op   <= bus.OpCodeIN;
      r_opb  <= w_opb;
      r_valb <= bus.ValBIN;
      r_vec  <= bus.VecIN;
      if (w_is_vec) begin
        r_result <= '0;
        r_zero   <= 1'b1;
        r_vecres <= '0;
      end else begin
        r_result <= w_scalar_res;
        r_zero   <= (w_scalar_res == '0);
      end
    end else if (r_state == BUSY) begin
      for (int l = 0; l < LANES; l++) begin
        r_vecres[(int'(r_cnt) * LANES + l) * DATA_W +: DATA_W] <=
          f_alu(r_alu, r_vec[(int'(r_cnt) * LANES + l) * DATA_W +: DATA_W], r_opb);
      end
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end
endmodule
